// File: rtl/block_stream_emitter.sv
// block_stream_emitter: expands BEGIN/END/CHAR commands into a byte-per-cycle ASCII stream, tracking nesting depth.
// Optional BLOCK_GUARD_EN suppresses END tokens at depth 0 so the stream never underflows.
module block_stream_emitter #(
   parameter int DEPTH_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [7:0]         cmd_char,
   output logic               out_valid,
   output logic [7:0]         out_char,
   output logic [DEPTH_W-1:0] depth,
   output logic               balanced,
   output logic               err
);
   localparam logic [1:0] OP_BEGIN = 2'd1, OP_END = 2'd2, OP_CHAR = 2'd3;
   typedef enum logic [1:0] {IDLE, PRESEP, KEY, POSTSEP} state_t;
   state_t     state, state_n;
   logic [2:0] idx, idx_n;
   logic       is_end, is_end_n;
   logic       valid_n;
   logic [7:0] char_n;
   logic       last_alpha;
   logic       accept, suppress, final_letter;

   function automatic logic [7:0] letter(input logic e, input logic [2:0] i);
      return e ? (i == 3'd0 ? 8'h65 : i == 3'd1 ? 8'h6e : 8'h64)
               : (i == 3'd0 ? 8'h62 : i == 3'd1 ? 8'h65 : i == 3'd2 ? 8'h67 : i == 3'd3 ? 8'h69 : 8'h6e);
   endfunction

   function automatic logic is_alpha(input logic [7:0] c);
      return (c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a);
   endfunction

   // CHAR bytes are presented while state stays IDLE, so ready is never dropped for them
   assign cmd_ready = state == IDLE || state == POSTSEP;
   assign accept = cmd_valid && cmd_ready;
`ifdef BLOCK_GUARD_EN
   assign suppress = accept && cmd_op == OP_END && depth == '0;
`else
   assign suppress = 1'b0;
`endif
   assign final_letter = state == KEY && idx == (is_end ? 3'd1 : 3'd3);
   assign balanced = depth == '0 && !err;

   always_comb begin
      state_n  = IDLE;
      idx_n    = idx;
      is_end_n = is_end;
      valid_n  = 1'b0;
      char_n   = 8'h00;
      if (accept) begin
         if (cmd_op == OP_CHAR) begin
            valid_n = 1'b1;
            char_n  = cmd_char;
         end else if ((cmd_op == OP_BEGIN || cmd_op == OP_END) && !suppress) begin
            is_end_n = cmd_op == OP_END;
            idx_n    = 3'd0;
            valid_n  = 1'b1;
            state_n  = last_alpha ? PRESEP : KEY;
            char_n   = last_alpha ? 8'h20 : letter(cmd_op == OP_END, 3'd0);
         end
      end else if (state == PRESEP) begin
         state_n = KEY;
         idx_n   = 3'd0;
         valid_n = 1'b1;
         char_n  = letter(is_end, 3'd0);
      end else if (state == KEY) begin
         valid_n = 1'b1;
         state_n = idx == (is_end ? 3'd2 : 3'd4) ? POSTSEP : KEY;
         idx_n   = state_n == KEY ? idx + 3'd1 : idx;
         char_n  = state_n == KEY ? letter(is_end, idx + 3'd1) : 8'h20;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= 3'd0;
         is_end     <= 1'b0;
         out_valid  <= 1'b0;
         out_char   <= 8'h00;
         depth      <= '0;
         err        <= 1'b0;
         last_alpha <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         is_end    <= is_end_n;
         out_valid <= valid_n;
         out_char  <= char_n;
         if (valid_n) last_alpha <= is_alpha(char_n);
         if (suppress) err <= 1'b1;
         // depth saturates at both ends; either overflow direction latches err
         if (final_letter) begin
            if (is_end) begin
               if (depth == '0) err <= 1'b1;
               else depth <= depth - 1'b1;
            end else begin
               if (&depth) err <= 1'b1;
               else depth <= depth + 1'b1;
            end
         end
      end
   end
endmodule
